// File: rtl/axis_msg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_msg_pkg
//  Purpose  : Shared types and helpers for the AXI-Stream message assembler.
//  Revision : 1.0 - initial multi-beat release
// ============================================================================
package axis_msg_pkg;

  // Assembler control states
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DROP    = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Widest tkeep the helpers accept; narrower keeps are zero-extended
  localparam int KEEP_MAX_W = 64;

  // Bits needed to hold a byte count in the range 0..max_bytes
  function automatic int len_bits(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Length width for the default 32-byte message buffer
  localparam int LEN_W = len_bits(32);

  // Number of asserted byte qualifiers
  function automatic int keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < KEEP_MAX_W; i++) cnt += int'(keep[i]);
    return cnt;
  endfunction

  // True when ones run contiguously from lane 0 (all-zero also qualifies):
  // adding one to such a mask carries cleanly out of the run of ones.
  function automatic logic keep_is_contiguous(input logic [KEEP_MAX_W-1:0] keep);
    return ((keep & (keep + 1'b1)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_msg_pack.sv
`default_nettype none
// ============================================================================
//  Module   : axis_msg_pack
//  Purpose  : Byte-granular merge of the low n lanes of a beat into the
//             message buffer starting at byte offset len (combinational).
//  Revision : 1.0 - initial multi-beat release
// ============================================================================
module axis_msg_pack
  import axis_msg_pkg::*;
#(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int LEN_W         = 6
) (
  input  logic [8*MAX_MSG_BYTES-1:0] i_buf,
  input  logic [LEN_W-1:0]           i_len,
  input  logic [8*DATA_BYTES-1:0]    i_tdata,
  input  logic [LEN_W-1:0]           i_n,
  output logic [8*MAX_MSG_BYTES-1:0] o_buf
);

  for (genvar b = 0; b < MAX_MSG_BYTES; b++) begin : g_byte
    logic [7:0] w_byte;

    // Buffer byte b takes lane (b - len) when that lane is among the first n
    always_comb begin
      w_byte = i_buf[8*b +: 8];
      for (int k = 0; k < DATA_BYTES; k++) begin
        if ((k < int'(i_n)) && ((int'(i_len) + k) == b)) w_byte = i_tdata[8*k +: 8];
      end
    end

    assign o_buf[8*b +: 8] = w_byte;
  end

endmodule
`default_nettype wire

// File: rtl/axis_msg_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : axis_msg_assembler
//  Purpose  : Packs tkeep-qualified AXI-Stream beats into a message buffer
//             and presents each completed message with length and error flag.
//  Revision : 1.0 - initial multi-beat release
// ============================================================================
module axis_msg_assembler
  import axis_msg_pkg::*;
#(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int CNT_W         = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_tvalid,
  output logic                                 s_tready,
  input  logic [8*DATA_BYTES-1:0]              s_tdata,
  input  logic [DATA_BYTES-1:0]                s_tkeep,
  input  logic                                 s_tlast,
  input  logic                                 s_tuser,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [8*MAX_MSG_BYTES-1:0]           m_data,
  output logic [$clog2(MAX_MSG_BYTES+1)-1:0]   m_len,
  output logic                                 m_error,
  output logic [CNT_W-1:0]                     msg_count,
  output logic [CNT_W-1:0]                     err_count
);

  localparam int c_LEN_W = $clog2(MAX_MSG_BYTES + 1);

  state_e                     r_state;
  logic [8*MAX_MSG_BYTES-1:0] r_buf;
  logic [c_LEN_W-1:0]         r_len;
  logic                       r_err;
  logic                       r_s_tready;
  logic                       r_m_valid;
  logic [8*MAX_MSG_BYTES-1:0] r_m_data;
  logic [c_LEN_W-1:0]         r_m_len;
  logic                       r_m_error;
  logic [CNT_W-1:0]           r_msg_cnt;
  logic [CNT_W-1:0]           r_err_cnt;

  int                         w_keep_n;
  int                         w_nbytes;
  logic                       w_contig;
  logic                       w_ovf;
  logic                       w_err_nxt;
  logic                       w_accept;
  logic                       w_done;
  logic [c_LEN_W-1:0]         w_n;
  logic [c_LEN_W-1:0]         w_len_sum;
  logic [8*MAX_MSG_BYTES-1:0] w_pack_buf;

  // Illegal keeps contribute nothing; overflow is judged on legal bytes only
  assign w_keep_n  = keep_popcount(KEEP_MAX_W'(s_tkeep));
  assign w_contig  = keep_is_contiguous(KEEP_MAX_W'(s_tkeep));
  assign w_nbytes  = w_contig ? w_keep_n : 0;
  assign w_n       = c_LEN_W'(w_nbytes);
  assign w_ovf     = (int'(r_len) + w_nbytes) > MAX_MSG_BYTES;
  assign w_len_sum = c_LEN_W'(int'(r_len) + w_nbytes);
  assign w_err_nxt = r_err | s_tuser | ~w_contig | w_ovf;
  assign w_accept  = s_tvalid & r_s_tready;
  assign w_done    = r_m_valid & m_ready;

  axis_msg_pack #(
    .DATA_BYTES    (DATA_BYTES),
    .MAX_MSG_BYTES (MAX_MSG_BYTES),
    .LEN_W         (c_LEN_W)
  ) u_pack (
    .i_buf   (r_buf),
    .i_len   (r_len),
    .i_tdata (s_tdata),
    .i_n     (w_n),
    .o_buf   (w_pack_buf)
  );

  // Message FSM: collect beats, discard after overflow, hold result until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= COLLECT;
      r_buf      <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_s_tready <= 1'b1;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_len    <= '0;
      r_m_error  <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_err <= w_err_nxt;
            if (!w_ovf) begin
              r_buf <= w_pack_buf;
              r_len <= w_len_sum;
            end
            if (s_tlast) begin
              r_state    <= EMIT;
              r_s_tready <= 1'b0;
              r_m_valid  <= 1'b1;
              r_m_error  <= w_err_nxt;
              // No error implies no overflow, so the merged buffer is valid
              r_m_data   <= w_err_nxt ? '0 : w_pack_buf;
              r_m_len    <= w_err_nxt ? '0 : w_len_sum;
            end else if (w_ovf) begin
              r_state <= DROP;
            end
          end
        end
        DROP: begin
          if (w_accept && s_tlast) begin
            r_state    <= EMIT;
            r_s_tready <= 1'b0;
            r_m_valid  <= 1'b1;
            r_m_error  <= 1'b1;
            r_m_data   <= '0;
            r_m_len    <= '0;
          end
        end
        EMIT: begin
          if (w_done) begin
            r_state    <= COLLECT;
            r_s_tready <= 1'b1;
            r_m_valid  <= 1'b0;
            r_buf      <= '0;
            r_len      <= '0;
            r_err      <= 1'b0;
          end
        end
        default: begin
          r_state    <= COLLECT;
          r_s_tready <= 1'b1;
          r_m_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating delivery counters, bumped once per consumed message
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msg_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_done) begin
      if (r_m_error) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end else begin
        if (r_msg_cnt != '1) r_msg_cnt <= r_msg_cnt + 1'b1;
      end
    end
  end

  assign s_tready  = r_s_tready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_len     = r_m_len;
  assign m_error   = r_m_error;
  assign msg_count = r_msg_cnt;
  assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_msg_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_msg_assembler
//  Purpose  : Scoreboard bench for axis_msg_assembler (8-byte beats, 32-byte
//             buffer, 3-bit counters so saturation is reachable).
//  Revision : 1.0 - initial multi-beat release
// ============================================================================
module tb_axis_msg_assembler;
  import axis_msg_pkg::*;

  localparam int DB      = 8;
  localparam int MB      = 32;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic             clk;
  logic             rst;
  logic             s_tvalid;
  logic             s_tready;
  logic [8*DB-1:0]  s_tdata;
  logic [DB-1:0]    s_tkeep;
  logic             s_tlast;
  logic             s_tuser;
  logic             m_valid;
  logic             m_ready;
  logic [8*MB-1:0]  m_data;
  logic [LEN_W-1:0] m_len;
  logic             m_error;
  logic [CW-1:0]    msg_count;
  logic [CW-1:0]    err_count;

  axis_msg_assembler #(
    .DATA_BYTES    (DB),
    .MAX_MSG_BYTES (MB),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_len     (m_len),
    .m_error   (m_error),
    .msg_count (msg_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8*MB-1:0] data;
    int              len;
    logic            err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         exp_msg = 0;
  int         exp_err = 0;

  // Reference message model
  logic [7:0] mdl_buf [MB];
  int         mdl_len;
  bit         mdl_err;
  bit         mdl_drop;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < MB; i++) mdl_buf[i] = 8'h00;
    mdl_len  = 0;
    mdl_err  = 1'b0;
    mdl_drop = 1'b0;
  endtask

  // Apply one accepted beat to the model; push the expected message on tlast
  task automatic mdl_beat(input logic [63:0] data, input logic [7:0] keep,
                          input logic last, input logic user);
    int n;
    bit ok;
    bit gap;
    exp_t e;
    n = 0; ok = 1'b1; gap = 1'b0;
    for (int i = 0; i < DB; i++) begin
      if (!keep[i]) gap = 1'b1;
      else begin
        if (gap) ok = 1'b0;
        n++;
      end
    end
    if (!ok) begin mdl_err = 1'b1; n = 0; end
    if (user) mdl_err = 1'b1;
    if (!mdl_drop) begin
      if (mdl_len + n > MB) begin
        mdl_err = 1'b1;
        if (!last) mdl_drop = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) mdl_buf[mdl_len + i] = data[8*i +: 8];
        mdl_len += n;
      end
    end
    if (last) begin
      e.err = mdl_err;
      e.len = mdl_err ? 0 : mdl_len;
      for (int i = 0; i < MB; i++) e.data[8*i +: 8] = mdl_err ? 8'h00 : mdl_buf[i];
      sb_q.push_back(e);
      mdl_clear();
    end
  endtask

  // Drive one beat, wait (bounded) for acceptance; called and returns at posedge+1
  task automatic send_beat(input logic [63:0] data, input logic [7:0] keep,
                           input logic last, input logic user);
    int t;
    bit acc;
    s_tvalid = 1'b1; s_tdata = data; s_tkeep = keep; s_tlast = last; s_tuser = user;
    t = 0; acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (s_tready) acc = 1'b1;
      else if (++t > 40) begin
        check("tready_timeout", 256'(s_tready), 256'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    if (acc) mdl_beat(data, keep, last, user);
  endtask

  function automatic logic [63:0] beat_data(input int base);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'(base + i);
    return d;
  endfunction

  // Bounded wait for all expected messages, then check counters
  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 256'(sb_q.size()), 256'(0));
    check({tag, "_msg_cnt"}, 256'(msg_count), 256'(exp_msg));
    check({tag, "_err_cnt"}, 256'(err_count), 256'(exp_err));
  endtask

  // Scoreboard: every handshake must match the oldest expected message
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      check("sb_nonempty", 256'(sb_q.size() != 0), 256'(1));
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("m_data",  256'(m_data),  256'(e.data));
        check("m_len",   256'(m_len),   256'(e.len));
        check("m_error", 256'(m_error), 256'(e.err));
        if (e.err) begin if (exp_err < CNT_MAX) exp_err++; end
        else       begin if (exp_msg < CNT_MAX) exp_msg++; end
      end
    end
  end

  initial begin
    rst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tlast = 1'b0; s_tuser = 1'b0; m_ready = 1'b1;
    mdl_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 256'(m_valid),   256'(0));
    check("rst_m_len",   256'(m_len),     256'(0));
    check("rst_m_error", 256'(m_error),   256'(0));
    check("rst_m_data",  256'(m_data),    256'(0));
    check("rst_msg_cnt", 256'(msg_count), 256'(0));
    check("rst_err_cnt", 256'(err_count), 256'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Four full beats exactly filling the buffer, byte k = k
    for (int b = 0; b < 4; b++) send_beat(beat_data(8*b), 8'hFF, b == 3, 1'b0);
    check("t1_latency_valid", 256'(m_valid), 256'(1));
    @(posedge clk); #1;
    check("t1_tready_back", 256'(s_tready), 256'(1));
    check("t1_msg_cnt",     256'(msg_count), 256'(1));
    wait_drain("t1");

    // Partial last beat: 8 + 3 bytes, upper bytes zero
    send_beat(beat_data(8'hA0), 8'hFF, 1'b0, 1'b0);
    send_beat(beat_data(8'hB0), 8'h07, 1'b1, 1'b0);
    wait_drain("t2");

    // Overflow on the tlast beat
    for (int b = 0; b < 5; b++) send_beat(beat_data(16*b), 8'hFF, b == 4, 1'b0);
    wait_drain("t3");

    // Overflow mid-message, tlast taken in DROP
    for (int b = 0; b < 6; b++) send_beat(beat_data(16*b + 3), 8'hFF, b == 5, 1'b0);
    wait_drain("t4");

    // Upstream error marker, then a non-contiguous keep
    send_beat(beat_data(8'h40), 8'hFF, 1'b0, 1'b1);
    send_beat(beat_data(8'h48), 8'hFF, 1'b1, 1'b0);
    send_beat(beat_data(8'h50), 8'h05, 1'b1, 1'b0);
    wait_drain("t5");

    // Variable-width contiguous beats at assorted offsets
    for (int m = 0; m < 4; m++) begin
      for (int b = 0; b < 3; b++)
        send_beat({$urandom, $urandom}, 8'((9'h1 << $urandom_range(0, 8)) - 1), b == 2, 1'b0);
    end
    wait_drain("t6");

    // Backpressure: hold m_ready low while the message sits in EMIT
    m_ready = 1'b0;
    send_beat(beat_data(8'h60), 8'hFF, 1'b0, 1'b0);
    send_beat(beat_data(8'h68), 8'h3F, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      check("hold_tready", 256'(s_tready), 256'(0));
      check("hold_valid",  256'(m_valid),  256'(1));
      check("hold_q",      256'(sb_q.size() != 0), 256'(1));
      if (sb_q.size() != 0) begin
        check("hold_data", 256'(m_data), 256'(sb_q[0].data));
        check("hold_len",  256'(m_len),  256'(sb_q[0].len));
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_drain("t7");

    // Asynchronous reset in the middle of a message
    send_beat(beat_data(8'h70), 8'hFF, 1'b0, 1'b0);
    send_beat(beat_data(8'h78), 8'hFF, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", 256'(m_valid),   256'(0));
    check("mid_rst_m_len",   256'(m_len),     256'(0));
    check("mid_rst_m_error", 256'(m_error),   256'(0));
    check("mid_rst_m_data",  256'(m_data),    256'(0));
    check("mid_rst_msg_cnt", 256'(msg_count), 256'(0));
    check("mid_rst_err_cnt", 256'(err_count), 256'(0));
    mdl_clear(); exp_msg = 0; exp_err = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_beat(beat_data(8'h90), 8'h0F, 1'b1, 1'b0);
    wait_drain("t8");

    // Zero-byte messages until the good counter saturates
    for (int m = 0; m < 9; m++) send_beat(64'h0, 8'h00, 1'b1, 1'b0);
    wait_drain("t9");
    check("sat_msg_cnt", 256'(msg_count), 256'(CNT_MAX));

    // Errored messages until the error counter saturates
    for (int m = 0; m < 9; m++) send_beat(beat_data(m), 8'h05, 1'b1, 1'b0);
    wait_drain("t10");
    check("sat_err_cnt", 256'(err_count), 256'(CNT_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_msg_assembler.md
Name: axis_msg_assembler

Overview:
- Multi-beat AXI-Stream message assembler, next generation of the single-beat message capture block.
- Packs a stream of DATA_BYTES-wide beats, qualified by tkeep, into a MAX_MSG_BYTES message buffer.
- Presents the completed message on a valid/ready output with byte length and an error flag.
- Drives s_tready for real backpressure. Sits between the ingress AXIS link and the message decoder.

Parameters:
- DATA_BYTES, 8: bytes per input beat; tkeep width equals DATA_BYTES.
- MAX_MSG_BYTES, 32: message buffer capacity in bytes; must be ≥ DATA_BYTES.
- CNT_W, 16: width of the status counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input beat ready
- s_tdata  in  8*DATA_BYTES  beat data; byte k is bits [8k+7:8k]
- s_tkeep  in  DATA_BYTES  byte qualifiers
- s_tlast  in  1  last beat of message
- s_tuser  in  1  upstream error marker, valid on any beat
- m_valid  out  1  message valid
- m_ready  in  1  message consumed
- m_data  out  8*MAX_MSG_BYTES  message; byte 0 is the first received byte; unused upper bytes are 0
- m_len  out  $clog2(MAX_MSG_BYTES+1)  valid byte count
- m_error  out  1  message is errored
- msg_count  out  CNT_W  good messages delivered, saturating
- err_count  out  CNT_W  errored messages delivered, saturating

Behaviour:
- Reset (rst low, asynchronous): state=COLLECT, buffer=0, len=0, err flag=0, m_valid=0, m_len=0, m_error=0, both counters=0. Reset mid-message discards the partial message.
- Beat accept: s_tvalid && s_tready at a rising clock edge.
- Legal tkeep: contiguous ones from lane 0, or all zero. Byte count n = popcount(s_tkeep).
- Illegal (non-contiguous) tkeep: sets the sticky err flag. The beat contributes no bytes.
- States:
  - COLLECT: s_tready=1.
    - Accepted beat: write bytes 0..n-1 to buffer offset len; len += n.
    - s_tuser=1 sets the sticky err flag.
    - Overflow (len+n > MAX_MSG_BYTES) sets the err flag and writes nothing.
    - tlast → EMIT.
    - Overflow without tlast → DROP.
  - DROP: s_tready=1. Beats are accepted and discarded. tlast → EMIT.
  - EMIT: s_tready=0, m_valid=1.
    - m_data, m_len and m_error are held stable until m_ready.
    - On m_valid && m_ready: clear buffer, len and err flag; increment the matching counter; next state COLLECT.
- Errored message output: m_error=1, m_data all 0, m_len=0.
- Good message output: m_error=0. m_data bytes ≥ m_len are 0 (zero padding).
- Latency: tlast accepted at edge N → m_valid=1 from cycle N+1. m_ready already high at N+1 means handshake at edge N+1 and s_tready=1 again in cycle N+2.
- Zero-byte message (single beat, tkeep=0, tlast=1): emitted with m_len=0, m_error=0.
- A tlast beat that exactly fills the buffer (len+n == MAX) is legal, not an overflow.
- s_tuser together with overflow: single error, counted once.
- Counters saturate at all-ones and do not wrap.
- All outputs are registered. No combinational path from m_ready to s_tready.

Decomposition:
- Shared package axis_msg_pkg holds:
  - state enum {COLLECT, DROP, EMIT}
  - function keep_popcount
  - function keep_is_contiguous
  - localparam LEN_W
- Sub-module axis_msg_pack, purely combinational: inputs buffer, len, tdata, n; output next buffer as a byte-granular shifted merge.
- FSM, counters and output registers stay in the top module.

Test Plan:
All scenarios use DATA_BYTES=8, MAX_MSG_BYTES=32.
- Four full beats, data 0x00..0x1F, tlast on beat 4, m_ready=1 → m_len=32, m_data byte k = k, m_error=0, m_valid exactly 1 cycle after beat 4, msg_count=1.
- Beat 1 tkeep=0xFF, beat 2 tkeep=0x07 with tlast → m_len=11, bytes 11..31 = 0, m_error=0.
- Five full beats, tlast on beat 5 → overflow on beat 5, that beat accepted, m_error=1, m_len=0, m_data=0, err_count=1.
- Six beats, overflow on beat 5, tlast on beat 6 → beat 6 accepted in DROP, m_error=1, err_count=1.
- Two beats with s_tuser=1 on beat 1, then tkeep=0x05 message → first message m_error=1. Second message (tkeep=0x05) also m_error=1.
- Hold m_ready=0 for 10 cycles in EMIT → s_tready=0 and m_* stable throughout. Assert rst low mid-message → all outputs 0, next message assembles from offset 0.
